// File: rtl/sprite_renderer.sv
// Sprite renderer: snapshots two packed player words once per frame and
// composites background, player sprites and health bars into an RGB332
// pixel stream through a 3-stage pipeline (S1 lookup, S2 texel, S3 output).
module sprite_renderer #(
  parameter int unsigned SPRITE_W  = 32,
  parameter int unsigned SPRITE_H  = 32,
  parameter int unsigned H_ACTIVE  = 640,
  parameter logic [7:0]  BG_COLOR  = 8'h25,
  parameter logic [7:0]  BAR_COLOR = 8'h1C,
  parameter int unsigned BAR_Y0    = 8,
  parameter int unsigned BAR_Y1    = 15,
  parameter int unsigned BAR_X0    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] sprites,
  input  logic        frame_start,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        pixel_valid,
  output logic [15:0] rom_addr_p1,
  output logic [15:0] rom_addr_p2,
  input  logic [7:0]  rom_data_p1,
  input  logic [7:0]  rom_data_p2,
  output logic [7:0]  pixel_out,
  output logic        pixel_valid_out
);

  // Word layout: {posx[8:0], posy[8:0], health[5:0], left, animation[3:0], frame[1:0], rsvd}
  logic [31:0] shadow_p1, shadow_p2;

  logic        s1_valid, s1_hit1, s1_hit2, s1_bar;
  logic        s2_valid, s2_hit1, s2_hit2, s2_bar;
  logic [7:0]  s2_tex1, s2_tex2;

  logic [16:0] lk1, lk2;
  logic [10:0] hx;
  logic [6:0]  bw1, bw2;
  logic        on_bar_line, bar1, bar2, bar_hit;
  logic [7:0]  pixel_next;

  logic unused_rsvd;
  assign unused_rsvd = shadow_p1[0] ^ shadow_p2[0];

  // Returns {hit, animation, frame, row, col}; out-of-range coordinate bits are masked to zero.
  function automatic logic [16:0] sprite_lookup(input logic [31:0] word,
                                                input logic [9:0]  hc,
                                                input logic [9:0]  vc);
    logic [10:0] dx, dy;
    logic [4:0]  col, row;
    logic        hit;
    dx  = {1'b0, hc} - {2'b00, word[31:23]};
    dy  = {1'b0, vc} - {2'b00, word[22:14]};
    hit = !dx[10] && (dx < 11'(SPRITE_W)) && !dy[10] && (dy < 11'(SPRITE_H));
    col = word[7] ? dx[4:0] : 5'(SPRITE_W - 1) - dx[4:0];
    col = col & 5'(SPRITE_W - 1);
    row = dy[4:0] & 5'(SPRITE_H - 1);
    return {hit, word[6:3], word[2:1], row, col};
  endfunction

  // Negative health (bit 5 set) means a dead player with no bar.
  function automatic logic [6:0] bar_width(input logic [5:0] health);
    return health[5] ? 7'd0 : {health[4:0], 2'b00};
  endfunction

  // Frame snapshot: sprites is only looked at on frame_start so a frame never tears.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_p1 <= '0;
      shadow_p2 <= '0;
    end else if (frame_start) begin
      shadow_p1 <= sprites[63:32];
      shadow_p2 <= sprites[31:0];
    end
  end

  // S1 combinational: sprite hit/address lookup and health bar coverage.
  // P2 bar test is written as hx + w > right_edge to avoid underflow.
  always_comb begin
    lk1         = sprite_lookup(shadow_p1, hcount, vcount);
    lk2         = sprite_lookup(shadow_p2, hcount, vcount);
    hx          = {1'b0, hcount};
    bw1         = bar_width(shadow_p1[13:8]);
    bw2         = bar_width(shadow_p2[13:8]);
    on_bar_line = (vcount >= 10'(BAR_Y0)) && (vcount <= 10'(BAR_Y1));
    bar1        = (hx >= 11'(BAR_X0)) && (hx < 11'(BAR_X0) + {4'b0000, bw1});
    bar2        = (hx <= 11'(H_ACTIVE - 1 - BAR_X0)) &&
                  (hx + {4'b0000, bw2} > 11'(H_ACTIVE - 1 - BAR_X0));
    bar_hit     = on_bar_line && (bar1 || bar2);
  end

  // S1 register: ROM addresses are driven every cycle regardless of hit.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_hit1     <= 1'b0;
      s1_hit2     <= 1'b0;
      s1_bar      <= 1'b0;
      rom_addr_p1 <= '0;
      rom_addr_p2 <= '0;
    end else begin
      s1_valid    <= pixel_valid;
      s1_hit1     <= pixel_valid & lk1[16];
      s1_hit2     <= pixel_valid & lk2[16];
      s1_bar      <= pixel_valid & bar_hit;
      rom_addr_p1 <= lk1[15:0];
      rom_addr_p2 <= lk2[15:0];
    end
  end

  // S2 register: capture ROM texels alongside their hit flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_hit1  <= 1'b0;
      s2_hit2  <= 1'b0;
      s2_bar   <= 1'b0;
      s2_tex1  <= '0;
      s2_tex2  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_hit1  <= s1_hit1;
      s2_hit2  <= s1_hit2;
      s2_bar   <= s1_bar;
      s2_tex1  <= rom_data_p1;
      s2_tex2  <= rom_data_p2;
    end
  end

  // S3 combinational: layer priority blanking > bars > p1 > p2 > background.
  always_comb begin
    pixel_next = BG_COLOR;
    if (!s2_valid)                     pixel_next = 8'h00;
    else if (s2_bar)                   pixel_next = BAR_COLOR;
    else if (s2_hit1 && s2_tex1 != '0) pixel_next = s2_tex1;
    else if (s2_hit2 && s2_tex2 != '0) pixel_next = s2_tex2;
  end

  // S3 output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      pixel_out       <= '0;
      pixel_valid_out <= 1'b0;
    end else begin
      pixel_out       <= pixel_next;
      pixel_valid_out <= s2_valid;
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer: the ROMs are modelled as constant texel
// sources so each expected pixel follows directly from the layer priority.
module tb_sprite_renderer;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] sprites;
  logic        frame_start;
  logic [9:0]  hcount, vcount;
  logic        pixel_valid;
  logic [15:0] rom_addr_p1, rom_addr_p2;
  logic [7:0]  rom_data_p1, rom_data_p2;
  logic [7:0]  pixel_out;
  logic        pixel_valid_out;

  logic [7:0]  tex1, tex2;
  int          checks = 0;
  int          fails  = 0;

  assign rom_data_p1 = tex1;
  assign rom_data_p2 = tex2;

  sprite_renderer #(
    .SPRITE_W (32),
    .SPRITE_H (32),
    .H_ACTIVE (640),
    .BG_COLOR (8'h25),
    .BAR_COLOR(8'h1C),
    .BAR_Y0   (8),
    .BAR_Y1   (15),
    .BAR_X0   (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .sprites        (sprites),
    .frame_start    (frame_start),
    .hcount         (hcount),
    .vcount         (vcount),
    .pixel_valid    (pixel_valid),
    .rom_addr_p1    (rom_addr_p1),
    .rom_addr_p2    (rom_addr_p2),
    .rom_data_p1    (rom_data_p1),
    .rom_data_p2    (rom_data_p2),
    .pixel_out      (pixel_out),
    .pixel_valid_out(pixel_valid_out)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [8:0] px, input logic [8:0] py,
                                     input logic [5:0] hp, input logic lf,
                                     input logic [3:0] an, input logic [1:0] fr);
    return {px, py, hp, lf, an, fr, 1'b0};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pix(input int h, input int v, input logic pv);
    hcount      = 10'(h);
    vcount      = 10'(v);
    pixel_valid = pv;
  endtask

  task automatic latch(input logic [31:0] w1, input logic [31:0] w2);
    sprites     = {w1, w2};
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic run_pixel(input int h, input int v, input logic pv,
                           output logic [7:0] po, output logic pvo);
    set_pix(h, v, pv);
    repeat (3) step();
    po  = pixel_out;
    pvo = pixel_valid_out;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    frame_start = 1'b0;
    sprites = '0;
    tex1 = 8'hE0;
    tex2 = 8'h77;
    set_pix(5, 5, 1'b1);
    step();
    step();
    checks++;
    if (pixel_out !== 8'h00) begin
      fails++; $display("FAIL reset_pixel_out: got %h expected 00", pixel_out);
    end
    checks++;
    if (pixel_valid_out !== 1'b0) begin
      fails++; $display("FAIL reset_valid_out: got %b expected 0", pixel_valid_out);
    end
    checks++;
    if (rom_addr_p1 !== 16'h0000 || rom_addr_p2 !== 16'h0000) begin
      fails++; $display("FAIL reset_rom_addr: got %h/%h expected 0000/0000", rom_addr_p1, rom_addr_p2);
    end
    set_pix(0, 0, 1'b0);
    reset = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_first_pixel();
    latch(32'h0, 32'h0);
    set_pix(0, 0, 1'b0);
    repeat (3) step();
    set_pix(0, 0, 1'b1);
    step();
    checks++;
    if (rom_addr_p1 !== 16'h001F) begin
      fails++; $display("FAIL first_rom_addr: got %h expected 001f", rom_addr_p1);
    end
    step();
    checks++;
    if (pixel_valid_out !== 1'b0) begin
      fails++; $display("FAIL first_latency_early: valid_out got %b expected 0", pixel_valid_out);
    end
    step();
    checks++;
    if (pixel_out !== 8'hE0 || pixel_valid_out !== 1'b1) begin
      fails++; $display("FAIL first_pixel: got %h/%b expected e0/1", pixel_out, pixel_valid_out);
    end
  endtask

  task automatic test_rom_addr();
    logic [7:0] po;
    logic       pvo;
    int         xs [8] = '{131, 132, 99, 100, 100, 533, 534, 501};
    int         ys [8] = '{205, 205, 205, 231, 232, 40, 40, 40};
    logic [7:0] ex [8] = '{8'hE0, 8'h25, 8'h25, 8'hE0, 8'h25, 8'hE0, 8'h25, 8'h25};
    tex1 = 8'hE0;
    tex2 = 8'h77;
    latch(mk(100, 200, 0, 0, 3, 2), mk(511, 511, 0, 0, 0, 0));
    set_pix(100, 205, 1'b1);
    step();
    checks++;
    if (rom_addr_p1 !== 16'h38BF) begin
      fails++; $display("FAIL rom_addr_mirrored: got %h expected 38bf", rom_addr_p1);
    end
    latch(mk(100, 200, 0, 1, 3, 2), mk(511, 511, 0, 0, 0, 0));
    step();
    checks++;
    if (rom_addr_p1 !== 16'h38A0) begin
      fails++; $display("FAIL rom_addr_left: got %h expected 38a0", rom_addr_p1);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 5) latch(mk(502, 40, 0, 1, 0, 0), mk(511, 511, 0, 0, 0, 0));
      run_pixel(xs[i], ys[i], 1'b1, po, pvo);
      checks++;
      if (po !== ex[i]) begin
        fails++; $display("FAIL sprite_edge(%0d,%0d): got %h expected %h", xs[i], ys[i], po, ex[i]);
      end
    end
    latch(mk(100, 200, 0, 1, 3, 2), mk(511, 511, 0, 0, 0, 0));
  endtask

  task automatic test_snapshot();
    logic [7:0] po;
    logic       pvo;
    tex1 = 8'hE0;
    sprites = {mk(400, 300, 0, 0, 0, 0), mk(511, 511, 0, 0, 0, 0)};
    run_pixel(100, 205, 1'b1, po, pvo);
    checks++;
    if (po !== 8'hE0) begin
      fails++; $display("FAIL snapshot_old_pos: got %h expected e0", po);
    end
    run_pixel(400, 300, 1'b1, po, pvo);
    checks++;
    if (po !== 8'h25) begin
      fails++; $display("FAIL snapshot_no_tear: got %h expected 25", po);
    end
    set_pix(400, 300, 1'b1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    step();
    checks++;
    if (pixel_out !== 8'h25) begin
      fails++; $display("FAIL snapshot_same_cycle: got %h expected 25", pixel_out);
    end
    step();
    checks++;
    if (pixel_out !== 8'hE0) begin
      fails++; $display("FAIL snapshot_next_cycle: got %h expected e0", pixel_out);
    end
  endtask

  task automatic test_overlap();
    logic [7:0] po;
    logic       pvo;
    latch(mk(300, 100, 0, 0, 1, 0), mk(300, 100, 0, 1, 2, 1));
    tex1 = 8'hFF; tex2 = 8'h03;
    run_pixel(310, 110, 1'b1, po, pvo);
    checks++;
    if (po !== 8'hFF) begin
      fails++; $display("FAIL overlap_p1_wins: got %h expected ff", po);
    end
    tex1 = 8'h00;
    run_pixel(310, 110, 1'b1, po, pvo);
    checks++;
    if (po !== 8'h03) begin
      fails++; $display("FAIL overlap_p1_transparent: got %h expected 03", po);
    end
    tex2 = 8'h00;
    run_pixel(310, 110, 1'b1, po, pvo);
    checks++;
    if (po !== 8'h25) begin
      fails++; $display("FAIL overlap_both_transparent: got %h expected 25", po);
    end
  endtask

  task automatic test_health_bars();
    logic [7:0] po;
    logic       pvo;
    int         xs [12] = '{16, 139, 140, 15, 623, 616, 615, 623, 624, 16, 16, 16};
    int         ys [12] = '{10, 10, 10, 10, 10, 10, 10, 10, 10, 7, 15, 16};
    logic [7:0] ex [12] = '{8'h1C, 8'h1C, 8'h25, 8'h25, 8'h25,
                            8'h1C, 8'h25, 8'h1C, 8'h25, 8'h25, 8'h1C, 8'h25};
    tex1 = 8'hE0; tex2 = 8'h77;
    latch(mk(511, 511, 31, 0, 0, 0), mk(511, 511, 6'b100110, 0, 0, 0));
    for (int i = 0; i < 12; i++) begin
      if (i == 5) latch(mk(511, 511, 31, 0, 0, 0), mk(511, 511, 2, 0, 0, 0));
      run_pixel(xs[i], ys[i], 1'b1, po, pvo);
      checks++;
      if (po !== ex[i]) begin
        fails++; $display("FAIL bar(%0d,%0d): got %h expected %h", xs[i], ys[i], po, ex[i]);
      end
    end
  endtask

  task automatic test_blank_and_reset();
    logic [7:0] po;
    logic       pvo;
    tex1 = 8'hE0; tex2 = 8'h77;
    latch(mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0));
    run_pixel(5, 5, 1'b0, po, pvo);
    checks++;
    if (po !== 8'h00 || pvo !== 1'b0) begin
      fails++; $display("FAIL blanking: got %h/%b expected 00/0", po, pvo);
    end
    run_pixel(5, 5, 1'b1, po, pvo);
    checks++;
    if (po !== 8'hE0 || pvo !== 1'b1) begin
      fails++; $display("FAIL visible_hit: got %h/%b expected e0/1", po, pvo);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (pixel_out !== 8'h00 || pixel_valid_out !== 1'b0 || rom_addr_p1 !== 16'h0000) begin
      fails++; $display("FAIL midline_reset: got %h/%b/%h expected 00/0/0000",
                        pixel_out, pixel_valid_out, rom_addr_p1);
    end
    for (int i = 1; i <= 2; i++) begin
      step();
      checks++;
      if (pixel_out !== 8'h00 || pixel_valid_out !== 1'b0) begin
        fails++; $display("FAIL reset_flush_cycle%0d: got %h/%b expected 00/0", i, pixel_out, pixel_valid_out);
      end
    end
    step();
    checks++;
    if (pixel_out !== 8'hE0 || pixel_valid_out !== 1'b1) begin
      fails++; $display("FAIL reset_recover: got %h/%b expected e0/1", pixel_out, pixel_valid_out);
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_rom_addr();
    test_snapshot();
    test_overlap();
    test_health_bars();
    test_blank_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sprite_renderer.md
Name: sprite_renderer

Overview:
- Pixel-side consumer of the 64-bit `sprites` bus driven by the game state machine.
- Snapshots both packed player words once per frame and decodes them into position, health, facing, animation and frame fields.
- Drives one sprite-ROM address per player and composites background, player sprites and health bars into an RGB332 pixel stream for the VGA output stage.

Parameters:
SPRITE_W, 32, sprite width in pixels (power of two, max 32)
SPRITE_H, 32, sprite height in pixels (power of two, max 32)
H_ACTIVE, 640, visible pixels per line
BG_COLOR, 8'h25, background colour (RGB332)
BAR_COLOR, 8'h1C, health bar colour
BAR_Y0, 8, first health bar line
BAR_Y1, 15, last health bar line
BAR_X0, 16, left edge of player 1 bar; player 2 bar right edge = H_ACTIVE-1-BAR_X0

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
sprites  in  64  {player1[31:0], player2[31:0]}; each word = {posx[8:0], posy[8:0], health[5:0], left, animation[3:0], frame[1:0], rsvd}
frame_start  in  1  one-cycle pulse during vertical blanking
hcount  in  10  current pixel x
vcount  in  10  current pixel y
pixel_valid  in  1  hcount/vcount in visible area
rom_addr_p1  out  16  {animation, frame, row[4:0], col[4:0]} for player 1
rom_addr_p2  out  16  same for player 2
rom_data_p1  in  8  texel for rom_addr_p1, valid 1 cycle after the address
rom_data_p2  in  8  texel for rom_addr_p2, same timing; 8'h00 = transparent
pixel_out  out  8  composited RGB332 pixel
pixel_valid_out  out  1  pixel_valid delayed to align with pixel_out

Behaviour:
- Reset (synchronous): shadow registers = 0; rom_addr_p1 = rom_addr_p2 = 0; pixel_out = 0; pixel_valid_out = 0; all pipeline valids = 0.
- Snapshot:
  - On a clock with frame_start = 1, latch the full 64-bit sprites word into the shadow registers.
  - The new values are used from the next cycle. sprites is ignored at all other times, so a frame never tears.
  - Bit 0 of each word is reserved and ignored.
- Pipeline: fixed 3-cycle latency from (hcount, vcount, pixel_valid) to (pixel_out, pixel_valid_out). It accepts a new pixel every cycle with no stalls.
  - S1, registered:
    - dx = hcount - posx and dy = vcount - posy, computed in 11-bit signed arithmetic with posx/posy zero-extended.
    - hit = pixel_valid & 0 <= dx < SPRITE_W & 0 <= dy < SPRITE_H.
    - col = dx when left = 1, else SPRITE_W-1-dx (mirrored).
    - row = dy.
    - rom_addr = {animation, frame, row, col}, padded with zeros when SPRITE_W/H < 32.
    - Compute the bar hit for both players; carry pixel_valid forward.
  - S2: rom_data arrives; register the texel with its hit flag and the bar flags.
  - S3, output register, priority from high to low:
    - pixel_valid = 0 → 8'h00
    - bar hit → BAR_COLOR
    - p1 hit & texel1 != 0 → texel1
    - p2 hit & texel2 != 0 → texel2
    - otherwise → BG_COLOR
- Health bars:
  - Bar width = 0 if health[5] = 1 (negative/dead); otherwise width = health*4 pixels (max 124).
  - Both bars occupy lines BAR_Y0..BAR_Y1.
  - P1 bar spans BAR_X0 .. BAR_X0+w-1.
  - P2 bar spans H_ACTIVE-BAR_X0-w .. H_ACTIVE-1-BAR_X0, right-aligned.
- Boundaries:
  - A sprite past the right/bottom edge is clipped naturally; there is no wrap.
  - posx = 9'h1F6 (502) draws at x 502..533.
  - Overlapping players: player 1 wins unless its texel is transparent.
  - Reset mid-line flushes the pipeline: pixel_valid_out = 0 for at least 3 cycles after reset releases.
  - frame_start asserted during active video is still honoured at once; the pixel after it uses the new snapshot.
- ROM addresses are driven every cycle, including when hit = 0; the ROM must tolerate reads of any address.

Test Plan:
- Reset then idle, pixel_valid = 1, sprites = 0 latched → (0,0) hits p1 with texel 8'hE0 → pixel_out = 8'hE0 exactly 3 cycles after input; pixel_valid_out aligned.
- P1 word posx = 100, posy = 200, left = 0, anim = 3, frame = 2; pixel (100,205) → rom_addr_p1 = {4'd3, 2'd2, 5'd5, 5'd31}; with left = 1 → col = 0.
- Change sprites mid-frame without frame_start → output unchanged; pulse frame_start → new position used from the next cycle.
- P1 and p2 both at posx = 300, posy = 100: texel1 = 8'hFF → 8'hFF; texel1 = 0, texel2 = 8'h03 → 8'h03; both 0 → BG_COLOR.
- P1 health = 31, p2 health = 6'b100110 → line 10: x = 16..139 BAR_COLOR, x = 140 BG_COLOR; no p2 bar.
- Pixel_valid = 0 during blanking with a sprite "hit" → pixel_out = 0; assert reset mid-line → pixel_out = 0 and pixel_valid_out = 0 until 3 cycles after release.
